// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned INIT_ZERO    = 0;
  localparam int unsigned INIT_INDEX   = 1;
  localparam int unsigned XLEN_DEFAULT = 64;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on a tie.
// Bit 0 is tied low so x0 never reports a pending producer.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [NREGS-1:0] sb_o
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_addr_i] = 1'b0;
    if (set_en_i) sb_d[set_addr_i] = 1'b1;
    if (clr_i)    sb_d = '0;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  assign sb_o = sb_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD combinational read ports, one write port,
// hardwired x0, optional write bypass, busy scoreboard and sequenced init.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned AW        = $clog2(NREGS),
  parameter int unsigned NRD       = 2,
  parameter int unsigned INIT_MODE = INIT_ZERO,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_req,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr
);

  localparam int unsigned CNT_W = AW + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] sb;

  logic             run_c;
  logic             wr_ok_c;
  logic             iss_ok_c;
  logic             restart_c;
  logic [XLEN-1:0]  init_val_c;

  // An init_req in RUN swallows any write or issue presented alongside it.
  assign run_c      = (state_q == RUN) && !init_req;
  assign restart_c  = (state_q == RUN) && init_req;
  assign wr_ok_c    = run_c && wr_en && (wr_addr != '0);
  assign iss_ok_c   = run_c && iss_en && (iss_addr != '0);
  assign init_val_c = (INIT_MODE == INIT_INDEX) ? XLEN'(cnt_q) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == CNT_W'(NREGS - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (init_req) begin
            state_q <= INIT;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the init sequence overwrites every entry before RUN.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem_q[cnt_q[AW-1:0]] <= init_val_c;
    else if (wr_ok_c)    mem_q[wr_addr]       <= wr_data;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (restart_c),
    .set_en_i   (iss_ok_c),
    .set_addr_i (iss_addr),
    .clr_en_i   (wr_ok_c),
    .clr_addr_i (wr_addr),
    .sb_o       (sb)
  );

  for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp;

    assign ra  = rd_addr[g*AW +: AW];
    assign byp = (BYPASS != 0) && wr_en && (wr_addr == ra);
    assign rd_data[g*XLEN +: XLEN] = (ready_q && (ra != '0)) ? (byp ? wr_data : mem_q[ra]) : '0;
    assign rd_busy[g] = ready_q && sb[ra] && !byp;
  end

  assign ready = ready_q;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (index image + bypass, zero image + no bypass)
// share stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned XL  = 64;
  localparam int unsigned NR  = 32;
  localparam int unsigned AWD = 5;
  localparam int unsigned NP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_req = 1'b0;
  logic wr_en = 1'b0;
  logic iss_en = 1'b0;
  logic [AWD-1:0] wr_addr = '0;
  logic [AWD-1:0] iss_addr = '0;
  logic [XL-1:0] wr_data = '0;
  logic [NP*AWD-1:0] rd_addr = '0;
  logic [NP*XL-1:0] rdata_a, rdata_b;
  logic [NP-1:0] busy_a, busy_b;
  logic ready_a, ready_b;

  int checks = 0;
  int errors = 0;

  // Reference model: d=0 is the bypass/index-image instance, d=1 the other.
  logic [XL-1:0] m_mem [2][NR];
  bit m_sb [NR];
  bit m_ready = 1'b0;
  int m_edges = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(NP), .INIT_MODE(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .init_req(init_req), .ready(ready_a),
    .rd_addr(rd_addr), .rd_data(rdata_a), .rd_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(NP), .INIT_MODE(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .init_req(init_req), .ready(ready_b),
    .rd_addr(rd_addr), .rd_data(rdata_b), .rd_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  function automatic logic [XL-1:0] dout(int d, int p);
    return (d == 0) ? rdata_a[p*XL +: XL] : rdata_b[p*XL +: XL];
  endfunction

  function automatic logic bout(int d, int p);
    return (d == 0) ? busy_a[p] : busy_b[p];
  endfunction

  function automatic logic [XL-1:0] exp_data(int d, logic [AWD-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (d == 0 && wr_en && wr_addr == a) return wr_data;
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(int d, logic [AWD-1:0] a);
    if (!m_ready || a == 0) return 1'b0;
    if (d == 0 && wr_en && wr_addr == a) return 1'b0;
    return m_sb[a];
  endfunction

  task automatic model_clear();
    m_ready = 1'b0;
    m_edges = 0;
    foreach (m_sb[i]) m_sb[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_ready) begin
      m_edges++;
      if (m_edges == NR) begin
        for (int i = 0; i < NR; i++) begin
          m_mem[0][i] = XL'(i);
          m_mem[1][i] = '0;
        end
        m_ready = 1'b1;
      end
    end else if (init_req) begin
      model_clear();
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[0][wr_addr] = wr_data;
        m_mem[1][wr_addr] = wr_data;
        m_sb[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_sb[iss_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0;
    iss_en = 1'b0;
    init_req = 1'b0;
  endtask

  task automatic set_rd(int p, logic [AWD-1:0] a);
    rd_addr[p*AWD +: AWD] = a;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_a && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int ea [4] = '{5, 31, 0, 1};
    rd_addr = 20'h8_4321;
    #2;
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0 || rdata_a !== '0 || busy_a !== '0 || busy_b !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b/%b busy=%h/%h, required 0", ready_a, ready_b, busy_a, busy_b);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_ready(n);
    checks++;
    if (n !== 32 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL init_timing: edges=%0d ready_b=%b, required 32 and 1", n, ready_b);
    end
    for (int p = 0; p < 4; p++) set_rd(p, AWD'(ea[p]));
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (dout(0, p) !== XL'(ea[p]) || dout(1, p) !== '0) begin
        errors++;
        $display("FAIL init_image port%0d: got %h/%h, required %h/0", p, dout(0, p), dout(1, p), ea[p]);
      end
    end
  endtask

  task automatic test_write_read();
    set_rd(0, 7);
    wr_en = 1'b1; wr_addr = 7; wr_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    checks++;
    if (dout(0, 0) !== 64'hDEAD_BEEF_0000_0001 || dout(1, 0) !== '0) begin
      errors++;
      $display("FAIL same_cycle_read: got %h/%h, required deadbeef00000001/0", dout(0, 0), dout(1, 0));
    end
    tick();
    idle();
    #1;
    checks++;
    if (dout(0, 0) !== 64'hDEAD_BEEF_0000_0001 || dout(1, 0) !== 64'hDEAD_BEEF_0000_0001) begin
      errors++;
      $display("FAIL write_then_read: got %h/%h, required deadbeef00000001", dout(0, 0), dout(1, 0));
    end
  endtask

  task automatic test_x0();
    rd_addr = '0;
    wr_en = 1'b1; wr_addr = 0; wr_data = '1;
    iss_en = 1'b1; iss_addr = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (rdata_a !== '0 || rdata_b !== '0 || busy_a !== '0 || busy_b !== '0) begin
        errors++;
        $display("FAIL x0_protect step%0d: data %h/%h busy %h/%h, required 0", k, rdata_a, rdata_b, busy_a, busy_b);
      end
      tick();
      idle();
    end
  endtask

  task automatic test_scoreboard();
    set_rd(0, 3);
    iss_en = 1'b1; iss_addr = 3;
    tick();
    idle();
    #1;
    checks++;
    if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue: busy %b/%b, required 1/1", busy_a[0], busy_b[0]);
    end
    wr_en = 1'b1; wr_addr = 3; wr_data = 64'h1234;
    iss_en = 1'b1; iss_addr = 3;
    tick();
    idle();
    #1;
    checks++;
    if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1 || dout(0, 0) !== 64'h1234 || dout(1, 0) !== 64'h1234) begin
      errors++;
      $display("FAIL sb_set_wins: busy %b/%b data %h/%h, required 1/1 1234", busy_a[0], busy_b[0], dout(0, 0), dout(1, 0));
    end
    wr_en = 1'b1; wr_addr = 3; wr_data = 64'h5678;
    #1;
    checks++;
    if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_bypass_hide: busy %b/%b, required 0/1", busy_a[0], busy_b[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: busy %b/%b, required 0/0", busy_a[0], busy_b[0]);
    end
  endtask

  task automatic test_init_req();
    int n;
    wr_en = 1'b1; wr_addr = 9; wr_data = 64'h55;
    iss_en = 1'b1; iss_addr = 4;
    tick();
    idle();
    set_rd(0, 9); set_rd(1, 4); set_rd(2, 2); set_rd(3, 0);
    #1;
    checks++;
    if (busy_a[1] !== 1'b1 || busy_b[1] !== 1'b1 || dout(1, 0) !== 64'h55) begin
      errors++;
      $display("FAIL pre_init_req: busy %b/%b x9=%h, required 1/1 55", busy_a[1], busy_b[1], dout(1, 0));
    end
    init_req = 1'b1;
    wr_en = 1'b1; wr_addr = 2; wr_data = 64'h77;
    tick();
    idle();
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      errors++;
      $display("FAIL init_req_ready: ready %b/%b, required 0/0", ready_a, ready_b);
    end
    wait_ready(n);
    #1;
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL init_req_timing: edges=%0d, required 32", n);
    end
    checks++;
    if (dout(1, 0) !== '0 || dout(1, 2) !== '0 || dout(0, 0) !== 64'd9 || dout(0, 2) !== 64'd2) begin
      errors++;
      $display("FAIL init_req_image: x9=%h/%h x2=%h/%h, required 9/0 2/0", dout(0, 0), dout(1, 0), dout(0, 2), dout(1, 2));
    end
    checks++;
    if (busy_a !== '0 || busy_b !== '0) begin
      errors++;
      $display("FAIL init_req_sb: busy %h/%h, required 0", busy_a, busy_b);
    end
  endtask

  task automatic test_random();
    logic [AWD-1:0] a;
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom);
      wr_addr = AWD'($urandom_range(0, 7));
      wr_data = {$urandom, $urandom};
      iss_en = 1'($urandom);
      iss_addr = AWD'($urandom_range(0, 7));
      init_req = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++) begin
        a = ($urandom_range(0, 3) == 0) ? wr_addr : AWD'($urandom_range(0, 8));
        set_rd(p, a);
      end
      #1;
      checks++;
      if (ready_a !== m_ready || ready_b !== m_ready) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: %b/%b, required %b", c, ready_a, ready_b, m_ready);
      end
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          a = rd_addr[p*AWD +: AWD];
          checks++;
          if (dout(d, p) !== exp_data(d, a) || bout(d, p) !== exp_busy(d, a)) begin
            errors++;
            $display("FAIL rand_read cyc%0d dut%0d port%0d addr%0d: data %h busy %b, required %h %b",
                     c, d, p, a, dout(d, p), bout(d, p), exp_data(d, a), exp_busy(d, a));
          end
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int n;
    logic [AWD-1:0] a;
    if (!m_ready) wait_ready(n);
    init_req = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_init: ready %b/%b, required 0/0", ready_a, ready_b);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reinit_timing: edges=%0d, required 32", n);
    end
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NP; p++) set_rd(p, AWD'($urandom));
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          a = rd_addr[p*AWD +: AWD];
          checks++;
          if (dout(d, p) !== exp_data(d, a) || bout(d, p) !== 1'b0) begin
            errors++;
            $display("FAIL reinit_read dut%0d port%0d addr%0d: data %h busy %b, required %h 0",
                     d, p, a, dout(d, p), bout(d, p), exp_data(d, a));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_init_req();
    test_random();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor of the single-write, two-read integer register file in the non-pipelined RISC-V datapath.
- Adds:
  - configurable width, depth and read-port count
  - hardwired x0
  - optional write-to-read bypass
  - a per-register busy scoreboard for multi-cycle writebacks
  - a sequenced initialisation engine that replaces the one-shot bulk reset.
- Sits between decode (read/issue) and writeback.

Parameters:
- XLEN, 64, data width of every register.
- NREGS, 32, number of architectural registers (power of two, >= 2).
- AW, $clog2(NREGS), register address width (derived; do not override).
- NRD, 2, number of combinational read ports (1..4).
- INIT_MODE, 0, initialisation pattern: 0 = all zero, 1 = reg[i] = i (debug/bring-up image).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads see stored value only.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- init_req  in  1  single-cycle pulse; restarts the init sequence while in RUN
- ready  out  1  high when in RUN (reads valid, writes accepted)
- rd_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has a pending (unwritten) result
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  issue of an instruction with a destination register
- iss_addr  in  AW  destination being issued; its busy bit is set

Behaviour:
- FSM states: INIT, RUN.
  - reset asserted (async) -> state INIT, init counter = 0, ready = 0, scoreboard = all 0.
  - Storage array is not reset directly.
- INIT:
  - Each cycle, writes reg[cnt] = (INIT_MODE ? cnt : 0), then cnt++.
  - After writing cnt = NREGS-1, moves to RUN next edge; ready rises then.
  - Init takes exactly NREGS cycles after reset deassertion.
- INIT rules:
  - wr_en, iss_en and init_req are ignored.
  - rd_data is forced to 0 and rd_busy to 0.
- RUN:
  - init_req = 1 -> INIT next edge, cnt = 0, scoreboard cleared.
  - wr_en and iss_en in that same cycle are dropped.
- Register x0:
  - Reads always return 0 and are never busy.
  - Writes and issues to address 0 are discarded.
  - INIT still writes 0 to x0.
- Write:
  - In RUN with wr_en and wr_addr != 0, reg[wr_addr] <= wr_data at the edge.
- Read:
  - Combinational.
  - rd_data[i] = 0 if rd_addr[i] == 0.
  - Else, if BYPASS and wr_en and wr_addr == rd_addr[i], rd_data[i] = wr_data.
  - Else rd_data[i] = reg[rd_addr[i]].
  - Multiple ports may read the same address.
- Scoreboard (NREGS bits; bit 0 constant 0):
  - iss_en sets bit[iss_addr] at the edge.
  - wr_en clears bit[wr_addr] at the edge.
  - Same address, same cycle: set wins (the new producer is outstanding). Data is still written.
- rd_busy[i]:
  - = sb[rd_addr[i]] & ~(BYPASS & wr_en & wr_addr == rd_addr[i]).
  - With bypass, the resolving write hides busy in its own cycle.
- Reset mid-INIT or mid-RUN: immediately returns to INIT with cnt = 0 and ready = 0; the full sequence restarts.
- Arithmetic: cnt is AW+1 bits wide so NREGS-1 compares without wrap. The INIT_MODE=1 value is cnt zero-extended to XLEN.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum {INIT, RUN}
  - INIT_ZERO/INIT_INDEX constants
  - the XLEN default
- One sub-module: regfile_scoreboard (set/clear bit vector with set-priority, async clear, sync clear input).
- Storage, bypass muxes and FSM stay in regfile_mp.

Test Plan:
- Init timing, INIT_MODE=1, NREGS=32: deassert reset -> ready rises exactly 32 edges later; reads of x5, x31 give 5, 31 (read x0 -> 0).
- Write then read: RUN, write x7 = 0xDEAD_BEEF_0000_0001 -> next cycle rd_data port0 (addr 7) equals it.
  - BYPASS=1: the same-cycle read already shows it.
  - BYPASS=0: the same-cycle read shows the old value.
- x0 protection: wr_en with wr_addr=0, data 0xFFFF... and iss_en addr 0 -> reads of x0 stay 0; rd_busy stays 0.
- Scoreboard: iss x3 -> rd_busy=1 for addr 3. wr x3 same cycle as iss x3 -> still busy next cycle. Plain wr x3 later -> busy clears, with rd_busy=0 during the write cycle if BYPASS=1.
- init_req in RUN with x9 = 0x55 and x4 busy, plus wr_en x2 = 0x77 in the same cycle -> ready low for 32 cycles. Afterwards x9 = 0 (INIT_MODE=0), scoreboard all 0, and x2 ≠ 0x77 (that write was dropped).
- Async reset mid-INIT at cnt=10 (asserted between edges) -> ready stays 0; after release the full 32-cycle sequence repeats; NRD=4 ports all read back correctly.
